aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
- Sequences one AES-128 block through the iterative round datapath: initial AddRoundKey, NR-1 full rounds, then a final round without MixColumns.
- Drives the per-stage enables, the round-key select and the data-input mux.
- Handshakes blocks in and out with valid/ready.
- Sits between the block I/O wrapper and the registered round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey) and the key schedule.

Parameters:
- NR, 10, number of rounds (10 for AES-128); legal range 2..15.
- STAGE_LAT, 1, cycles each round occupies in the registered datapath; legal range 1..4.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  new plaintext block available
- in_ready  output  1  controller accepts a block this cycle
- key_ready  input  1  round key for the current round_idx is valid
- abort  input  1  synchronous flush; return to IDLE
- out_valid  output  1  datapath output register holds the finished ciphertext
- out_ready  input  1  consumer takes the block
- load_sel  output  1  1: datapath input mux selects the new plaintext; 0: selects feedback
- round_idx  output  4  current round 0..NR; also the key-schedule select
- sub_en  output  1  enable for SubBytes/ShiftRows stage
- mix_en  output  1  enable for MixColumns stage
- ark_en  output  1  enable for AddRoundKey output register
- last_round  output  1  high while round_idx==NR
- busy  output  1  state != IDLE

Behaviour:
- States: IDLE, INIT, ROUND, FINAL, DONE. Internal stage counter sc (0..STAGE_LAT-1).
- Reset (async, rst_n low):
  - State IDLE; round_idx=0; sc=0.
  - All outputs 0 except in_ready=1.
  - Reset mid-operation discards the block; no out_valid follows.
- in_ready = (state==IDLE) || (state==DONE && out_ready). A transfer is in_valid&&in_ready.
- IDLE:
  - Transfer -> INIT, round_idx=0, sc=0.
  - Otherwise hold.
- INIT:
  - load_sel=1.
  - ark_en=key_ready.
  - sub_en=mix_en=0.
- ROUND (round_idx 1..NR-1):
  - sub_en=mix_en=ark_en=key_ready.
  - load_sel=0.
- FINAL (round_idx=NR):
  - sub_en=ark_en=key_ready; mix_en=0.
  - last_round=1.
- Stage counting (INIT/ROUND/FINAL):
  - Each cycle with key_ready=1 advances sc.
  - When sc==STAGE_LAT-1 the round completes: sc->0, round_idx increments.
  - Next state is ROUND if the new idx < NR, FINAL if it equals NR, and DONE after FINAL completes.
  - key_ready=0 is a stall: every enable is 0; sc, round_idx and state hold. Stall may last any number of cycles.
- DONE:
  - out_valid=1; all enables 0.
  - round_idx stays at NR; last_round=0.
  - out_valid holds until out_ready.
  - out_ready without in_valid -> IDLE.
  - out_ready with in_valid -> back-to-back accept straight into INIT (round_idx=0) the next cycle.
- Latency: with no stalls, out_valid rises (NR+1)*STAGE_LAT+1 cycles after the accepting edge. Defaults give 12 cycles.
- abort:
  - Highest priority after reset, in any state.
  - Next cycle: IDLE, round_idx=0, sc=0, out_valid=0.
  - in_ready is forced 0 while abort=1.
- Enables are combinational from state/sc/key_ready and are never high in IDLE or DONE.
- round_idx never exceeds NR. sc never exceeds STAGE_LAT-1.

Test Plan:
- Reset release, in_valid=1 at cycle 0, key_ready=1, out_ready=1, defaults:
  - round_idx 0,1..10 on cycles 1..11.
  - mix_en low on cycles 1 and 11.
  - out_valid on cycle 12.
  - Ciphertext for FIPS-197 key 000102..0f / pt 00112233..ff is 69c4e0d8..c55a.
- key_ready low for 3 cycles at round_idx=5:
  - All enables 0 and round_idx holds at 5 during the stall.
  - out_valid is delayed exactly 3 cycles (cycle 15).
  - Ciphertext is unchanged.
- out_ready low for 4 cycles after out_valid:
  - out_valid holds high; in_ready=0.
  - Block is accepted on the first out_ready high cycle.
  - IDLE follows.
- in_valid continuously high, out_ready=1:
  - Second block is accepted in the DONE cycle.
  - out_valid recurs every 12 cycles.
  - busy never drops.
- abort at round_idx=7:
  - Next cycle IDLE, round_idx=0; out_valid never asserts.
  - The next block runs clean to the correct ciphertext.
- rst_n pulsed low at round_idx=4:
  - All outputs return to reset values asynchronously.
  - No out_valid follows.
- Run the first scenario again with STAGE_LAT=2: out_valid at cycle 23.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: steps one AES block through INIT, NR-1 full rounds and FINAL,
// driving stage enables, round-key select and input mux with valid/ready handshakes.
module aes_round_ctrl #(
  parameter int NR        = 10,
  parameter int STAGE_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       key_ready,
  input  logic       abort,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       load_sel,
  output logic [3:0] round_idx,
  output logic       sub_en,
  output logic       mix_en,
  output logic       ark_en,
  output logic       last_round,
  output logic       busy
);
  localparam int SCW = STAGE_LAT > 1 ? $clog2(STAGE_LAT) : 1;
  localparam logic [SCW-1:0] SC_LAST = SCW'(STAGE_LAT - 1);
  localparam logic [3:0] IDX_LAST = 4'(NR);
  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_e;
  state_e         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [SCW-1:0] sc_q, sc_d;
  logic           active, step, xfer;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sc_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sc_q    <= sc_d;
    end
  assign active = state_q inside {INIT, ROUND, FINAL};
  assign step   = active && key_ready;
  assign xfer   = in_valid && in_ready;
  // A round completes on the last stage cycle; FINAL keeps idx at NR into DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sc_d    = sc_q;
    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
      sc_d    = '0;
    end else if (xfer) begin
      state_d = INIT;
      idx_d   = '0;
      sc_d    = '0;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
      idx_d   = '0;
    end else if (step) begin
      sc_d = sc_q == SC_LAST ? '0 : sc_q + 1'b1;
      if (sc_q == SC_LAST) begin
        idx_d   = state_q == FINAL ? idx_q : idx_q + 4'd1;
        state_d = state_q == FINAL ? DONE : (idx_q + 4'd1 == IDX_LAST ? FINAL : ROUND);
      end
    end
  end
  always_comb begin
    in_ready   = !abort && (state_q == IDLE || (state_q == DONE && out_ready));
    out_valid  = state_q == DONE;
    load_sel   = state_q == INIT;
    round_idx  = idx_q;
    ark_en     = step;
    sub_en     = key_ready && (state_q == ROUND || state_q == FINAL);
    mix_en     = key_ready && state_q == ROUND;
    last_round = state_q == FINAL;
    busy       = state_q != IDLE;
  end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: checks STAGE_LAT=1 and STAGE_LAT=2 controllers against a progress-count model.
module tb_aes_round_ctrl;
  localparam int NR = 10;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, key_ready = 0, abort = 0, out_ready = 0;
  logic       in_ready[2], out_valid[2], load_sel[2], sub_en[2], mix_en[2];
  logic       ark_en[2], last_round[2], busy[2];
  logic [3:0] round_idx[2];
  int errors = 0, checks = 0;
  bit held[2];
  int prog[2];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    aes_round_ctrl #(.NR(NR), .STAGE_LAT(g + 1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[g]),
      .key_ready(key_ready), .abort(abort), .out_valid(out_valid[g]),
      .out_ready(out_ready), .load_sel(load_sel[g]), .round_idx(round_idx[g]),
      .sub_en(sub_en[g]), .mix_en(mix_en[g]), .ark_en(ark_en[g]),
      .last_round(last_round[g]), .busy(busy[g]));
  end
  // Model: a held block has consumed prog productive cycles; round = prog / STAGE_LAT.
  always @(posedge clk or negedge rst_n)
    for (int i = 0; i < 2; i++)
      if (!rst_n) begin
        held[i] <= 0;
        prog[i] <= 0;
      end else if (abort) begin
        held[i] <= 0;
        prog[i] <= 0;
      end else if (!held[i]) begin
        if (in_valid) begin
          held[i] <= 1;
          prog[i] <= 0;
        end
      end else if (prog[i] < (NR + 1) * (i + 1)) begin
        if (key_ready) prog[i] <= prog[i] + 1;
      end else if (out_ready) begin
        if (in_valid) prog[i] <= 0;
        else held[i] <= 0;
      end
  function automatic logic [11:0] expv(int i);
    int  sl = i + 1;
    bit  dn = held[i] && prog[i] == (NR + 1) * sl;
    bit  cp = held[i] && !dn;
    int  r  = dn ? NR : (held[i] ? prog[i] / sl : 0);
    return {!abort && (!held[i] || (dn && out_ready)), dn, cp && r == 0, 4'(r),
            cp && key_ready && r >= 1, cp && key_ready && r >= 1 && r < NR,
            cp && key_ready, cp && r == NR, held[i]};
  endfunction
  function automatic logic [11:0] actv(int i);
    return {in_ready[i], out_valid[i], load_sel[i], round_idx[i], sub_en[i],
            mix_en[i], ark_en[i], last_round[i], busy[i]};
  endfunction
  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", n, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("model_sl1", 32'(actv(0)), 32'(expv(0)));
    chk("model_sl2", 32'(actv(1)), 32'(expv(1)));
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic flush();
    abort = 1;
    tick();
    abort = 0;
    in_valid = 0;
    key_ready = 1;
    out_ready = 1;
  endtask
  initial begin
    tick();
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready[0]), 1);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_idx", 32'(round_idx[0]), 0);
    tick();
    rst_n = 1;
    in_valid = 1; key_ready = 1; out_ready = 1;
    for (int c = 1; c <= 23; c++) begin
      tick();
      if (c == 1) in_valid = 0;
      @(negedge clk);
      if (c <= 11) chk("run_idx", 32'(round_idx[0]), 32'(c - 1));
      if (c == 1 || c == 11) chk("run_mix_low", 32'(mix_en[0]), 0);
      if (c == 11 || c == 12) chk("run_ov_sl1", 32'(out_valid[0]), 32'(c == 12));
      if (c == 22 || c == 23) chk("run_ov_sl2", 32'(out_valid[1]), 32'(c == 23));
    end
    flush();
    in_valid = 1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 1) in_valid = 0;
      key_ready = !(c >= 6 && c <= 8);
      @(negedge clk);
      if (c >= 6 && c <= 8) begin
        chk("stall_idx", 32'(round_idx[0]), 5);
        chk("stall_en", 32'({sub_en[0], mix_en[0], ark_en[0]}), 0);
      end
      if (c >= 14) chk("stall_ov", 32'(out_valid[0]), 32'(c == 15));
    end
    flush();
    in_valid = 1; out_ready = 0;
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (c == 1) in_valid = 0;
      if (c == 16) out_ready = 1;
      @(negedge clk);
      if (c >= 12 && c <= 16) begin
        chk("bp_ov", 32'(out_valid[0]), 1);
        chk("bp_in_ready", 32'(in_ready[0]), 32'(c == 16));
      end
      if (c == 17) chk("bp_idle", 32'(busy[0]), 0);
    end
    flush();
    in_valid = 1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      @(negedge clk);
      chk("b2b_busy", 32'(busy[0]), 1);
      chk("b2b_ov", 32'(out_valid[0]), 32'(c % 12 == 0));
    end
    flush();
    in_valid = 1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) in_valid = 0;
      if (c == 8) abort = 1;
      @(negedge clk);
    end
    chk("abort_idx7", 32'(round_idx[0]), 7);
    chk("abort_in_ready", 32'(in_ready[0]), 0);
    tick();
    abort = 0;
    in_valid = 1;
    @(negedge clk);
    chk("abort_idle", 32'({busy[0], round_idx[0]}), 0);
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 1) in_valid = 0;
      @(negedge clk);
      chk("post_abort_ov", 32'(out_valid[0]), 32'(c == 12));
    end
    flush();
    in_valid = 1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) in_valid = 0;
      @(negedge clk);
    end
    chk("rstp_idx4", 32'(round_idx[0]), 4);
    #2 rst_n = 0;
    #1;
    chk("rstp_async", 32'(actv(0)), 32'(12'h800));
    chk("rstp_async_sl2", 32'(actv(1)), 32'(12'h800));
    @(posedge clk);
    #1 rst_n = 1;
    for (int c = 0; c < 30; c++) begin
      tick();
      @(negedge clk);
      chk("rstp_no_ov", 32'(out_valid[0] | out_valid[1]), 0);
    end
    for (int c = 0; c < 3000; c++) begin
      tick();
      in_valid  = $urandom_range(1, 0) == 1;
      key_ready = $urandom_range(3, 0) != 0;
      out_ready = $urandom_range(4, 0) > 1;
      abort     = $urandom_range(40, 0) == 0;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
